// File: rtl/ctrl_pkg.sv
// Shared types and constants for the core control sequencer.
// Holds the state encoding, opcode map and the opcode classifier.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_ALU     = 3'd0,
    C_LOAD    = 3'd1,
    C_STORE   = 3'd2,
    C_BRANCH  = 3'd3,
    C_HALT    = 3'd4,
    C_MODESW  = 3'd5,
    C_ILLEGAL = 3'd6
  } op_class_t;

  localparam logic [4:0] OP_LOAD       = 5'b10000;
  localparam logic [4:0] OP_STORE      = 5'b10001;
  localparam logic [4:0] OP_BRANCH     = 5'b10010;
  localparam logic [4:0] OP_HALT       = 5'b11110;
  localparam logic [4:0] OP_MODESW     = 5'b11111;
  localparam logic [4:0] OP_MODESW_IMM = 5'b00111;

  localparam int DEFAULT_MEM_TIMEOUT = 15;

  // Mode 1 only knows opcodes 0..7; anything with an upper bit set is a fault.
  function automatic op_class_t classify(input logic [4:0] op, input logic mode);
    op_class_t c;
    c = C_ALU;
    if (mode == 1'b0) begin
      case (op)
        OP_LOAD:   c = C_LOAD;
        OP_STORE:  c = C_STORE;
        OP_BRANCH: c = C_BRANCH;
        OP_HALT:   c = C_HALT;
        OP_MODESW: c = C_MODESW;
        default:   c = C_ALU;
      endcase
    end else begin
      if (op[4:3] != 2'b00) begin
        c = C_ILLEGAL;
      end else if (op == OP_MODESW_IMM) begin
        c = C_MODESW;
      end else begin
        c = C_ALU;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts data-memory wait cycles; Expired flags the cycle that would
// reach LIMIT non-ready cycles.
module mem_wait_timer
  import ctrl_pkg::*;
#(
  parameter int LIMIT = DEFAULT_MEM_TIMEOUT
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Clear,
  input  logic Enable,
  output logic Expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
  localparam logic [CW-1:0] FULL = CW'(LIMIT);

  logic [CW-1:0] count_r;

  // Wait counter: clear has priority, then count non-ready cycles up to LIMIT.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      count_r <= {CW{1'b0}};
    end else if (Clear) begin
      count_r <= {CW{1'b0}};
    end else if (Enable && (count_r != FULL)) begin
      count_r <= count_r + CW'(1);
    end
  end

  assign Expired = Enable && (count_r == LAST);

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer that also
// owns the reg-reg / reg-immediate mode bit fed to the Decoder.
module ctrl_sequencer
  import ctrl_pkg::*;
#(
  parameter int OPW         = 5,
  parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
  parameter int CNTW        = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [OPW-1:0]  Opcode,
  input  logic            BranchTaken,
  input  logic            MemReady,
  output logic            Mode,
  output logic            IrLoad,
  output logic            PcInc,
  output logic            PcLoad,
  output logic            PcClear,
  output logic            RegWrite,
  output logic            MemReq,
  output logic            MemWrite,
  output logic            Done,
  output logic            Error,
  output logic [CNTW-1:0] InstCount,
  output logic [2:0]      State
);

  state_t          state_r;
  state_t          next_state_s;
  op_class_t       op_class_s;
  logic            mode_r;
  logic            done_r;
  logic            error_r;
  logic [CNTW-1:0] inst_count_r;
  logic            toggle_mode_s;
  logic            set_error_s;
  logic            restart_s;
  logic            retire_s;
  logic            timer_clear_s;
  logic            timer_en_s;
  logic            timer_expired_s;

  // Opcode is the 5-bit Decoder field; classification depends on the live mode.
  assign op_class_s = classify(Opcode[4:0], mode_r);

  assign timer_en_s    = (state_r == S_MEM) && !MemReady;
  assign timer_clear_s = restart_s || ((next_state_s == S_MEM) && (state_r != S_MEM));
  assign retire_s      = (next_state_s == S_FETCH) &&
                         ((state_r == S_EXEC) || (state_r == S_MEM) || (state_r == S_WB));

  mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .Clear   (timer_clear_s),
    .Enable  (timer_en_s),
    .Expired (timer_expired_s)
  );

  // Next-state and pulse outputs.
  always_comb begin
    next_state_s  = state_r;
    IrLoad        = 1'b0;
    PcInc         = 1'b0;
    PcLoad        = 1'b0;
    PcClear       = 1'b0;
    RegWrite      = 1'b0;
    MemReq        = 1'b0;
    MemWrite      = 1'b0;
    toggle_mode_s = 1'b0;
    set_error_s   = 1'b0;
    restart_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (Start) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        IrLoad       = 1'b1;
        next_state_s = S_DECODE;
      end
      S_DECODE: begin
        next_state_s = S_EXEC;
      end
      S_EXEC: begin
        case (op_class_s)
          C_ALU:   next_state_s = S_WB;
          C_LOAD:  next_state_s = S_MEM;
          C_STORE: next_state_s = S_MEM;
          C_BRANCH: begin
            next_state_s = S_FETCH;
            if (BranchTaken) begin
              PcLoad = 1'b1;
            end else begin
              PcInc = 1'b1;
            end
          end
          C_MODESW: begin
            next_state_s  = S_FETCH;
            PcInc         = 1'b1;
            toggle_mode_s = 1'b1;
          end
          C_HALT: next_state_s = S_HALT;
          default: begin
            next_state_s = S_HALT;
            set_error_s  = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        MemReq = 1'b1;
        if (op_class_s == C_STORE) begin
          MemWrite = 1'b1;
        end else begin
          MemWrite = 1'b0;
        end
        // A ready in the final allowed cycle completes rather than faults.
        if (MemReady) begin
          if (op_class_s == C_STORE) begin
            PcInc        = 1'b1;
            next_state_s = S_FETCH;
          end else begin
            next_state_s = S_WB;
          end
        end else if (timer_expired_s) begin
          set_error_s  = 1'b1;
          next_state_s = S_HALT;
        end else begin
          next_state_s = S_MEM;
        end
      end
      S_WB: begin
        RegWrite     = 1'b1;
        PcInc        = 1'b1;
        next_state_s = S_FETCH;
      end
      S_HALT: begin
        if (Start) begin
          PcClear      = 1'b1;
          restart_s    = 1'b1;
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_HALT;
        end
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

  // State register and architectural status.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_r      <= S_IDLE;
      mode_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      inst_count_r <= {CNTW{1'b0}};
    end else begin
      state_r <= next_state_s;
      if (restart_s) begin
        mode_r  <= 1'b0;
        done_r  <= 1'b0;
        error_r <= 1'b0;
      end else begin
        if (toggle_mode_s) begin
          mode_r <= ~mode_r;
        end
        if (next_state_s == S_HALT) begin
          done_r <= 1'b1;
        end
        if (set_error_s) begin
          error_r <= 1'b1;
        end
      end
      if (retire_s && (inst_count_r != {CNTW{1'b1}})) begin
        inst_count_r <= inst_count_r + CNTW'(1);
      end
    end
  end

  assign Mode      = mode_r;
  assign Done      = done_r;
  assign Error     = error_r;
  assign InstCount = inst_count_r;
  assign State     = state_r;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench: an instruction-level model expands each instruction into
// its expected per-cycle outputs, and a negedge process compares them.
module tb_ctrl_sequencer;

  localparam int OPW   = 5;
  localparam int MEM_T = 15;
  localparam int CNTW  = 4;
  localparam int MAXC  = (1 << CNTW) - 1;

  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_BRANCH = 3;
  localparam int K_HALT = 4, K_MODESW = 5, K_ILL = 6;

  // Pulse vector order: IrLoad PcInc PcLoad PcClear RegWrite MemReq MemWrite
  localparam logic [6:0] P_NONE = 7'b0000000;
  localparam logic [6:0] P_IR   = 7'b1000000;
  localparam logic [6:0] P_INC  = 7'b0100000;
  localparam logic [6:0] P_LD   = 7'b0010000;
  localparam logic [6:0] P_CLR  = 7'b0001000;
  localparam logic [6:0] P_WB   = 7'b0100100;
  localparam logic [6:0] P_MRD  = 7'b0000010;
  localparam logic [6:0] P_MWR  = 7'b0000011;

  logic            Clk = 1'b0;
  logic            Reset, Start, BranchTaken, MemReady;
  logic [OPW-1:0]  Opcode;
  logic            Mode, IrLoad, PcInc, PcLoad, PcClear, RegWrite;
  logic            MemReq, MemWrite, Done, Error;
  logic [CNTW-1:0] InstCount;
  logic [2:0]      State;

  typedef struct packed {
    logic [2:0]      st;
    logic [6:0]      p;
    logic            mode;
    logic            done;
    logic            err;
    logic [CNTW-1:0] cnt;
  } exp_t;

  exp_t expq[$];
  exp_t cmp_e;
  int   errors = 0;
  int   checks = 0;
  bit   m_mode, m_done, m_error;
  int   m_count;
  int   n;

  ctrl_sequencer #(
    .OPW(OPW), .MEM_TIMEOUT(MEM_T), .CNTW(CNTW)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Opcode(Opcode),
    .BranchTaken(BranchTaken), .MemReady(MemReady), .Mode(Mode),
    .IrLoad(IrLoad), .PcInc(PcInc), .PcLoad(PcLoad), .PcClear(PcClear),
    .RegWrite(RegWrite), .MemReq(MemReq), .MemWrite(MemWrite),
    .Done(Done), .Error(Error), .InstCount(InstCount), .State(State)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge Clk) begin
    if (expq.size() > 0) begin
      cmp_e = expq.pop_front();
      chk("state", 32'(State), 32'(cmp_e.st));
      chk("pulses", 32'({IrLoad, PcInc, PcLoad, PcClear, RegWrite, MemReq, MemWrite}), 32'(cmp_e.p));
      chk("status", 32'({Mode, Done, Error}), 32'({cmp_e.mode, cmp_e.done, cmp_e.err}));
      chk("count", 32'(InstCount), 32'(cmp_e.cnt));
    end
  end

  function automatic int cls_of(input int op, input bit md);
    if (md) begin
      if (op == 7) return K_MODESW;
      if (op < 7) return K_ALU;
      return K_ILL;
    end
    case (op)
      16: return K_LOAD;
      17: return K_STORE;
      18: return K_BRANCH;
      30: return K_HALT;
      31: return K_MODESW;
      default: return K_ALU;
    endcase
  endfunction

  task automatic retire();
    if (m_count < MAXC) m_count++;
  endtask

  task automatic model_reset();
    m_mode = 1'b0; m_done = 1'b0; m_error = 1'b0; m_count = 0;
  endtask

  // One clock cycle: drive inputs, queue this cycle's expected outputs.
  task automatic cyc(input int st, input logic [6:0] p, input bit start,
                     input bit rst, input bit bt, input bit rdy);
    exp_t e;
    Start = start; Reset = rst; BranchTaken = bt; MemReady = rdy;
    e.st = 3'(st); e.p = p; e.mode = m_mode; e.done = m_done;
    e.err = m_error; e.cnt = CNTW'(m_count);
    expq.push_back(e);
    @(posedge Clk); #1;
  endtask

  // k = non-ready MEM cycles before MemReady; sn drives Start as noise.
  task automatic run_instr(input int op, input bit bt, input int k,
                           input bit sn, output int nc);
    int cls;
    bit got, st_op;
    nc = 0;
    Opcode = OPW'(op);
    cls = cls_of(op, m_mode);
    st_op = (cls == K_STORE);
    cyc(1, P_IR, sn, 1'b1, bt, 1'b0); nc++;
    cyc(2, P_NONE, sn, 1'b1, bt, 1'b0); nc++;
    if (cls == K_BRANCH) cyc(3, bt ? P_LD : P_INC, sn, 1'b1, bt, 1'b0);
    else if (cls == K_MODESW) cyc(3, P_INC, sn, 1'b1, bt, 1'b0);
    else cyc(3, P_NONE, sn, 1'b1, bt, 1'b0);
    nc++;
    case (cls)
      K_ALU: begin cyc(5, P_WB, sn, 1'b1, bt, 1'b0); nc++; retire(); end
      K_BRANCH: retire();
      K_MODESW: begin retire(); m_mode = !m_mode; end
      K_HALT: m_done = 1'b1;
      K_ILL: begin m_done = 1'b1; m_error = 1'b1; end
      default: begin
        got = 1'b0;
        for (int i = 0; i < MEM_T && !got; i++) begin
          if (i == k) begin
            cyc(4, st_op ? (P_MWR | P_INC) : P_MRD, sn, 1'b1, bt, 1'b1);
            got = 1'b1;
          end else begin
            cyc(4, st_op ? P_MWR : P_MRD, sn, 1'b1, bt, 1'b0);
          end
          nc++;
        end
        if (!got) begin m_done = 1'b1; m_error = 1'b1; end
        else if (st_op) retire();
        else begin cyc(5, P_WB, sn, 1'b1, bt, 1'b0); nc++; retire(); end
      end
    endcase
  endtask

  task automatic halt_wait(input int cnt);
    for (int i = 0; i < cnt; i++) cyc(6, P_NONE, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic restart();
    cyc(6, P_CLR, 1'b1, 1'b1, 1'b0, 1'b0);
    m_mode = 1'b0; m_done = 1'b0; m_error = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b0; Start = 1'b0; BranchTaken = 1'b0; MemReady = 1'b0;
    Opcode = '0;
    model_reset();
    @(posedge Clk); @(posedge Clk); #1;
    cyc(0, P_NONE, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pin_reset_state", 32'(State), 0);

    cyc(0, P_NONE, 1'b1, 1'b1, 1'b0, 1'b0);
    run_instr(1, 1'b0, 0, 1'b0, n);
    chk("lat_alu", n, 4);
    chk("pin_count_alu", 32'(InstCount), 1);

    run_instr(31, 1'b0, 0, 1'b0, n);
    chk("lat_modesw", n, 3);
    chk("pin_mode_on", 32'(Mode), 1);
    run_instr(3, 1'b0, 0, 1'b0, n);
    chk("lat_alu_imm", n, 4);
    run_instr(7, 1'b0, 0, 1'b0, n);
    chk("pin_mode_off", 32'(Mode), 0);

    run_instr(18, 1'b1, 0, 1'b1, n);
    chk("lat_branch", n, 3);
    run_instr(18, 1'b0, 0, 1'b1, n);
    run_instr(19, 1'b1, 0, 1'b1, n);
    run_instr(29, 1'b0, 0, 1'b0, n);

    run_instr(16, 1'b0, 3, 1'b0, n);
    chk("lat_load_k3", n, 8);
    run_instr(16, 1'b0, 0, 1'b0, n);
    chk("lat_load_k0", n, 5);
    run_instr(17, 1'b0, 0, 1'b0, n);
    chk("lat_store_k0", n, 4);
    run_instr(17, 1'b0, MEM_T - 1, 1'b1, n);
    chk("lat_store_last", n, 18);

    run_instr(17, 1'b0, 100, 1'b0, n);
    chk("pin_timeout_err", 32'({Done, Error}), 3);
    halt_wait(2);
    restart();
    chk("pin_count_kept", 32'(InstCount), 12);
    chk("pin_done_clear", 32'(Done), 0);

    run_instr(30, 1'b0, 0, 1'b0, n);
    halt_wait(1);
    restart();

    run_instr(31, 1'b0, 0, 1'b0, n);
    run_instr(8, 1'b0, 0, 1'b0, n);
    chk("pin_illegal", 32'({Done, Error}), 3);
    halt_wait(1);
    restart();
    chk("pin_mode_restart", 32'(Mode), 0);

    for (int i = 0; i < 4; i++) run_instr(18, i[0], 0, 1'b0, n);
    chk("pin_saturate", 32'(InstCount), 15);

    Opcode = 5'b10000;
    cyc(1, P_IR, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(2, P_NONE, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(3, P_NONE, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(4, P_MRD, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(4, P_MRD, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    cyc(0, P_NONE, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("pin_rst_mem", 32'({State, MemReq, InstCount, Mode}), 0);

    cyc(0, P_NONE, 1'b1, 1'b1, 1'b0, 1'b0);
    run_instr(2, 1'b0, 0, 1'b0, n);
    chk("pin_count_after_rst", 32'(InstCount), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
